machine_csr_file: RTL and testbench

- Parametrised machine-mode CSR register file; next generation of the CSR package, instantiated as a stateful block beside the execute stage.
- Executes Zicsr read/write/set/clear accesses with per-register WARL write masks.
- Owns 64-bit cycle/instret/time counters, trap entry and mret sequencing, and interrupt-pending generation toward the control unit.

---
 rtl/machine_csr_file.sv | 250 +++++++++++++++++++++++++
 tb/tb_machine_csr_file.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: Zicsr accesses, 64-bit counters, trap/mret sequencing, interrupt pending.
// Optional mcountinhibit (0x320) is enabled by defining CSR_MCOUNTINHIBIT_EN.
module machine_csr_file #(
  parameter int          XLEN     = 32,
  parameter int          HARTID   = 0,
  parameter logic [31:0] MISA_VAL = 32'h40000100,
  parameter int          CNT_W    = 64,
  parameter int          TIME_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            retire_valid,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out,
  output logic            irq_pending
);

  localparam int HI_W = CNT_W - 32;

  localparam logic [11:0] A_MSTATUS    = 12'h300;
  localparam logic [11:0] A_MISA       = 12'h301;
  localparam logic [11:0] A_MEDELEG    = 12'h302;
  localparam logic [11:0] A_MIDELEG    = 12'h303;
  localparam logic [11:0] A_MIE        = 12'h304;
  localparam logic [11:0] A_MTVEC      = 12'h305;
  localparam logic [11:0] A_MCOUNTEREN = 12'h306;
  localparam logic [11:0] A_MCOUNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH   = 12'h340;
  localparam logic [11:0] A_MEPC       = 12'h341;
  localparam logic [11:0] A_MCAUSE     = 12'h342;
  localparam logic [11:0] A_MTVAL      = 12'h343;
  localparam logic [11:0] A_MIP        = 12'h344;
  localparam logic [11:0] A_MHARTID    = 12'hF14;
  localparam logic [11:0] A_MCYCLE     = 12'hB00;
  localparam logic [11:0] A_MINSTRET   = 12'hB02;
  localparam logic [11:0] A_MCYCLEH    = 12'hB80;
  localparam logic [11:0] A_MINSTRETH  = 12'hB82;
  localparam logic [11:0] A_TIME       = 12'hC01;
  localparam logic [11:0] A_TIMEH      = 12'hC81;

  logic            mstatus_mie_reg, mstatus_mpie_reg;
  logic [XLEN-1:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [XLEN-1:0] mcounteren_reg, medeleg_reg, mideleg_reg;
  logic [CNT_W-1:0] mtime_reg;
  logic [31:0]     prescale_reg;
  logic            irq_pending_reg;
  logic            inh_cy, inh_ir;

  logic [XLEN-1:0] mip_val, old_val, wmask, wval_raw, wval, time_hi;
  logic            implemented, read_only, write_attempt, illegal_c, wr_en, time_tick;
  logic [1:0][XLEN-1:0] cnt_lo, cnt_hi;
  logic [1:0]      inc_en;

`ifdef CSR_MCOUNTINHIBIT_EN
  logic inh_cy_reg, inh_ir_reg;
  assign inh_cy = inh_cy_reg;
  assign inh_ir = inh_ir_reg;
`else
  assign inh_cy = 1'b0;
  assign inh_ir = 1'b0;
`endif

  assign mip_val = {20'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};

  always_comb begin
    time_hi = '0;
    time_hi[HI_W-1:0] = mtime_reg[CNT_W-1:32];
  end

  // Address decode: old value, legality class and WARL write mask.
  always_comb begin
    implemented = 1'b1;
    read_only   = 1'b0;
    old_val     = '0;
    wmask       = '1;
    case (csr_addr)
      A_MSTATUS: begin
        old_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
        wmask   = 32'h0000_0088;
      end
      A_MISA:       begin old_val = MISA_VAL; read_only = 1'b1; end
      A_MEDELEG:    old_val = medeleg_reg;
      A_MIDELEG:    old_val = mideleg_reg;
      A_MIE:        begin old_val = mie_reg; wmask = 32'h0000_0888; end
      A_MTVEC:      begin old_val = mtvec_reg; wmask = 32'hFFFF_FFFD; end
      A_MCOUNTEREN: begin old_val = mcounteren_reg; wmask = 32'h0000_0007; end
`ifdef CSR_MCOUNTINHIBIT_EN
      A_MCOUNTINH:  begin old_val = {29'd0, inh_ir_reg, 1'b0, inh_cy_reg}; wmask = 32'h0000_0005; end
`endif
      A_MSCRATCH:   old_val = mscratch_reg;
      A_MEPC:       begin old_val = mepc_reg; wmask = 32'hFFFF_FFFC; end
      A_MCAUSE:     old_val = mcause_reg;
      A_MTVAL:      old_val = mtval_reg;
      A_MIP:        begin old_val = mip_val; read_only = 1'b1; end
      A_MHARTID:    begin old_val = XLEN'(HARTID); read_only = 1'b1; end
      A_MCYCLE:     old_val = cnt_lo[0];
      A_MINSTRET:   old_val = cnt_lo[1];
      A_MCYCLEH:    old_val = cnt_hi[0];
      A_MINSTRETH:  old_val = cnt_hi[1];
      A_TIME:       begin old_val = mtime_reg[31:0]; read_only = 1'b1; end
      A_TIMEH:      begin old_val = time_hi; read_only = 1'b1; end
      default:      implemented = 1'b0;
    endcase
  end

  assign write_attempt = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != '0));
  assign illegal_c     = csr_valid && (!implemented || (read_only && write_attempt));
  assign wr_en         = csr_valid && write_attempt && !illegal_c && !trap_valid && !mret_valid;

  always_comb begin
    case (csr_op)
      2'b01:   wval_raw = csr_wdata;
      2'b10:   wval_raw = old_val | csr_wdata;
      2'b11:   wval_raw = old_val & ~csr_wdata;
      default: wval_raw = old_val;
    endcase
    wval = (wval_raw & wmask) | (old_val & ~wmask);
  end

  assign csr_rdata   = (!rst && csr_valid && !illegal_c) ? old_val : '0;
  assign csr_illegal = !rst && illegal_c;
  assign mepc_out    = mepc_reg;
  assign irq_pending = irq_pending_reg;

  // Vectored mode only redirects interrupts; exceptions always use the base.
  always_comb begin
    trap_vector = {mtvec_reg[XLEN-1:2], 2'b00};
    if (mtvec_reg[0] && trap_cause[XLEN-1])
      trap_vector = trap_vector + {25'd0, trap_cause[4:0], 2'b00};
    if (rst)
      trap_vector = '0;
  end

  assign inc_en = {retire_valid & ~inh_ir, ~inh_cy};

  // mcycle (0) and minstret (1): a half-write overrides the increment of that half.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [11:0] LO_ADDR = 12'hB00 + 12'(2 * gi);
      localparam logic [11:0] HI_ADDR = 12'hB80 + 12'(2 * gi);
      logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
      logic [XLEN-1:0]  hi_ext;

      always_comb begin
        cnt_inc  = cnt_reg + CNT_W'(inc_en[gi]);
        cnt_next = cnt_inc;
        if (wr_en && csr_addr == LO_ADDR)
          cnt_next = {cnt_reg[CNT_W-1:32], wval};
        else if (wr_en && csr_addr == HI_ADDR)
          cnt_next = {wval[HI_W-1:0], cnt_inc[31:0]};
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_next;
      end

      always_comb begin
        hi_ext = '0;
        hi_ext[HI_W-1:0] = cnt_reg[CNT_W-1:32];
      end

      assign cnt_lo[gi] = cnt_reg[31:0];
      assign cnt_hi[gi] = hi_ext;
    end
  endgenerate

  assign time_tick = (prescale_reg == 32'(TIME_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_reg    <= '0;
      mtime_reg       <= '0;
      irq_pending_reg <= 1'b0;
    end else begin
      prescale_reg    <= time_tick ? 32'd0 : prescale_reg + 32'd1;
      mtime_reg       <= mtime_reg + CNT_W'(time_tick);
      irq_pending_reg <= ((mip_val & mie_reg & 32'h0000_0888) != '0) && mstatus_mie_reg;
    end
  end

  // Trap beats mret beats a CSR write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= '0;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      mcounteren_reg   <= '0;
      medeleg_reg      <= '0;
      mideleg_reg      <= '0;
`ifdef CSR_MCOUNTINHIBIT_EN
      inh_cy_reg       <= 1'b0;
      inh_ir_reg       <= 1'b0;
`endif
    end else if (trap_valid) begin
      mepc_reg         <= trap_pc & ~XLEN'(3);
      mcause_reg       <= trap_cause;
      mtval_reg        <= trap_tval;
      mstatus_mpie_reg <= mstatus_mie_reg;
      mstatus_mie_reg  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie_reg  <= mstatus_mpie_reg;
      mstatus_mpie_reg <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstatus_mie_reg  <= wval[3];
          mstatus_mpie_reg <= wval[7];
        end
        A_MEDELEG:    medeleg_reg    <= wval;
        A_MIDELEG:    mideleg_reg    <= wval;
        A_MIE:        mie_reg        <= wval;
        A_MTVEC:      mtvec_reg      <= wval;
        A_MCOUNTEREN: mcounteren_reg <= wval;
`ifdef CSR_MCOUNTINHIBIT_EN
        A_MCOUNTINH: begin
          inh_cy_reg <= wval[0];
          inh_ir_reg <= wval[2];
        end
`endif
        A_MSCRATCH:   mscratch_reg   <= wval;
        A_MEPC:       mepc_reg       <= wval;
        A_MCAUSE:     mcause_reg     <= wval;
        A_MTVAL:      mtval_reg      <= wval;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_csr_file.sv
// Randomised bench for machine_csr_file against a cycle-level reference model.
module tb_machine_csr_file;

  localparam int TDIV = 3;
  localparam int HART = 7;

  logic        clk, rst, csr_valid, retire_valid, trap_valid, mret_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, trap_cause, trap_pc, trap_tval;
  logic        irq_msip, irq_mtip, irq_meip;
  logic [31:0] csr_rdata, trap_vector, mepc_out;
  logic        csr_illegal, irq_pending;

  machine_csr_file #(.HARTID(HART), .TIME_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .retire_valid(retire_valid), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit        m_mie_b, m_mpie_b, m_irq;
  bit [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcounteren, m_medeleg, m_mideleg;
  bit [2:0]  m_inh;
  bit [63:0] m_cycle, m_instret, m_time;
  int        m_div;

  function automatic void mdl_read(input logic [11:0] a, output bit impl, output bit ro, output logic [31:0] v);
    impl = 1'b1;
    v = 32'd0;
    case (a)
      12'h300: v = {19'd0, 2'b11, 3'd0, m_mpie_b, 3'd0, m_mie_b, 3'd0};
      12'h301: v = 32'h4000_0100;
      12'h302: v = m_medeleg;
      12'h303: v = m_mideleg;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h306: v = m_mcounteren;
`ifdef CSR_MCOUNTINHIBIT_EN
      12'h320: v = {29'd0, m_inh[2], 1'b0, m_inh[0]};
`endif
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = {20'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};
      12'hF14: v = HART;
      12'hB00: v = m_cycle[31:0];
      12'hB02: v = m_instret[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB82: v = m_instret[63:32];
      12'hC01: v = m_time[31:0];
      12'hC81: v = m_time[63:32];
      default: impl = 1'b0;
    endcase
    ro = (a[11:8] == 4'hC) || (a == 12'hF14) || (a == 12'h301) || (a == 12'h344);
  endfunction

  function automatic logic [31:0] mdl_mask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h88;
      12'h304: return 32'h888;
      12'h305: return ~32'h2;
      12'h306: return 32'h7;
      12'h320: return 32'h5;
      12'h341: return ~32'h3;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit is_write();
    return (csr_op == 2'b01) || (csr_op[1] && csr_wdata != 32'd0);
  endfunction

  task automatic mdl_step();
    bit impl, ro, irq_n;
    logic [31:0] old, nv, msk, mipv;
    bit [63:0] cy_n, ir_n;
    if (rst) begin
      {m_mie_b, m_mpie_b, m_irq} = '0;
      {m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval} = '0;
      {m_mcounteren, m_medeleg, m_mideleg, m_inh} = '0;
      {m_cycle, m_instret, m_time} = '0;
      m_div = 0;
      return;
    end
    mipv  = {20'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};
    irq_n = ((mipv & m_mie & 32'h888) != 0) && m_mie_b;
    cy_n  = m_cycle + (m_inh[0] ? 64'd0 : 64'd1);
    ir_n  = m_instret + ((retire_valid && !m_inh[2]) ? 64'd1 : 64'd0);
    mdl_read(csr_addr, impl, ro, old);
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'd3;
      m_mcause = trap_cause;
      m_mtval = trap_tval;
      m_mpie_b = m_mie_b;
      m_mie_b = 1'b0;
    end else if (mret_valid) begin
      m_mie_b = m_mpie_b;
      m_mpie_b = 1'b1;
    end else if (csr_valid && impl && is_write() && !ro) begin
      case (csr_op)
        2'b01:   nv = csr_wdata;
        2'b10:   nv = old | csr_wdata;
        default: nv = old & ~csr_wdata;
      endcase
      msk = mdl_mask(csr_addr);
      nv = (nv & msk) | (old & ~msk);
      case (csr_addr)
        12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
        12'h302: m_medeleg = nv;
        12'h303: m_mideleg = nv;
        12'h304: m_mie = nv;
        12'h305: m_mtvec = nv;
        12'h306: m_mcounteren = nv;
        12'h320: m_inh = nv[2:0];
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: cy_n = {m_cycle[63:32], nv};
        12'hB02: ir_n = {m_instret[63:32], nv};
        12'hB80: cy_n = {nv, cy_n[31:0]};
        12'hB82: ir_n = {nv, ir_n[31:0]};
        default: ;
      endcase
    end
    m_cycle = cy_n;
    m_instret = ir_n;
    m_irq = irq_n;
    m_div++;
    if (m_div == TDIV) begin
      m_time++;
      m_div = 0;
    end
  endtask

  logic [31:0] last_rdata, last_tv;
  logic        last_ill, last_irq;

  // Check all outputs against the model mid-cycle, then advance both across one edge.
  task automatic do_cycle();
    bit impl, ro, ill;
    logic [31:0] v, tv;
    #1;
    mdl_read(csr_addr, impl, ro, v);
    ill = csr_valid && (!impl || (ro && is_write()));
    tv = {m_mtvec[31:2], 2'b00};
    if (m_mtvec[0] && trap_cause[31]) tv = tv + {25'd0, trap_cause[4:0], 2'b00};
    check_eq("rdata", csr_rdata, (!rst && csr_valid && !ill) ? v : 32'd0);
    check_eq("illegal", csr_illegal, !rst && ill);
    check_eq("trap_vector", trap_vector, rst ? 32'd0 : tv);
    check_eq("mepc_out", mepc_out, m_mepc);
    check_eq("irq_pending", irq_pending, m_irq);
    last_rdata = csr_rdata; last_ill = csr_illegal; last_tv = trap_vector; last_irq = irq_pending;
    @(posedge clk);
    mdl_step();
    @(negedge clk);
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    do_cycle();
    csr_valid = 1'b0;
  endtask

  logic [11:0] addr_tab [22] = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305, 12'h306,
                                 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hF14,
                                 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC01, 12'hC81, 12'h7C0, 12'hC00};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit [31:0] frozen;
    rst = 1'b1; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = 12'h300; csr_wdata = 32'd0;
    retire_valid = 1'b0; trap_valid = 1'b0; trap_cause = 32'd0; trap_pc = 32'd0; trap_tval = 32'd0;
    mret_valid = 1'b0; irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
    @(posedge clk);
    mdl_step();
    @(negedge clk);
    acc(2'b01, 12'h300, 32'hFFFF_FFFF);
    check_eq("reset_rdata", last_rdata, 32'd0);
    rst = 1'b0;

    acc(2'b00, 12'h340, 32'd0);
    check_eq("mscratch_pre", last_rdata, 32'd0);
    acc(2'b01, 12'h340, 32'hDEAD_BEEF);
    acc(2'b00, 12'h340, 32'd0);
    check_eq("mscratch_post", last_rdata, 32'hDEAD_BEEF);
    check_eq("mscratch_ill", last_ill, 1'b0);

    acc(2'b01, 12'h300, 32'hFFFF_FFFF);
    acc(2'b00, 12'h300, 32'd0);
    check_eq("mstatus_rw", last_rdata, 32'h0000_1888);
    acc(2'b11, 12'h300, 32'h8);
    acc(2'b00, 12'h300, 32'd0);
    check_eq("mstatus_rc", last_rdata, 32'h0000_1880);

    acc(2'b01, 12'hB80, 32'd0);
    acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    acc(2'b00, 12'hB00, 32'd0);
    check_eq("mcycle_pre", last_rdata, 32'hFFFF_FFFF);
    acc(2'b00, 12'hB80, 32'd0);
    check_eq("mcycleh_carry", last_rdata, 32'd1);
    acc(2'b01, 12'hB80, 32'd0);
    acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    acc(2'b01, 12'hB80, 32'd5);
    acc(2'b00, 12'hB80, 32'd0);
    check_eq("mcycleh_override", last_rdata, 32'd5);

    acc(2'b01, 12'h305, 32'h1001);
    acc(2'b01, 12'h304, 32'h80);
    acc(2'b10, 12'h300, 32'h8);
    irq_mtip = 1'b1;
    do_cycle();
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h2002; trap_tval = 32'h55;
    do_cycle();
    check_eq("irq_pending_set", last_irq, 1'b1);
    check_eq("trap_vector_vec", last_tv, 32'h101C);
    trap_valid = 1'b0; irq_mtip = 1'b0;
    acc(2'b00, 12'h300, 32'd0);
    check_eq("mstatus_trap", last_rdata, 32'h0000_1880);
    mret_valid = 1'b1;
    do_cycle();
    mret_valid = 1'b0;
    acc(2'b00, 12'h300, 32'd0);
    check_eq("mstatus_mret", last_rdata, 32'h0000_1888);
    acc(2'b00, 12'h341, 32'd0);
    check_eq("mepc_trap", last_rdata, 32'h2000);

    acc(2'b01, 12'hF14, 32'd1);
    check_eq("ill_hartid_wr", last_ill, 1'b1);
    check_eq("ill_hartid_rd", last_rdata, 32'd0);
    acc(2'b10, 12'hC01, 32'd1);
    check_eq("ill_time_rs", last_ill, 1'b1);
    acc(2'b00, 12'h7C0, 32'd0);
    check_eq("ill_unimpl", last_ill, 1'b1);
    acc(2'b10, 12'hC01, 32'd0);
    check_eq("time_rs0_legal", last_ill, 1'b0);
    acc(2'b00, 12'hF14, 32'd0);
    check_eq("hartid", last_rdata, 32'(HART));

    trap_valid = 1'b1; trap_pc = 32'h3007; trap_cause = 32'h2;
    acc(2'b01, 12'h341, 32'h1234);
    trap_valid = 1'b0;
    acc(2'b00, 12'h341, 32'd0);
    check_eq("mepc_trap_wins", last_rdata, 32'h3004);

`ifdef CSR_MCOUNTINHIBIT_EN
    acc(2'b01, 12'h320, 32'h1);
    frozen = m_cycle[31:0];
    for (int i = 0; i < 10; i++) begin
      acc(2'b00, 12'hB00, 32'd0);
      check_eq("mcycle_frozen", last_rdata, frozen);
    end
    acc(2'b01, 12'h320, 32'h0);
`else
    frozen = 32'd0;
    acc(2'b00, 12'h320, frozen);
    check_eq("mcountinhibit_absent", last_ill, 1'b1);
`endif

    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      csr_valid    = ($urandom_range(0, 3) != 0);
      csr_op       = 2'($urandom_range(0, 3));
      csr_addr     = addr_tab[$urandom_range(0, 21)];
      csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      retire_valid = 1'($urandom_range(0, 1));
      trap_valid   = ($urandom_range(0, 15) == 0);
      mret_valid   = ($urandom_range(0, 15) == 0);
      trap_cause   = $urandom();
      trap_pc      = $urandom();
      trap_tval    = $urandom();
      irq_msip     = 1'($urandom_range(0, 1));
      irq_mtip     = 1'($urandom_range(0, 1));
      irq_meip     = 1'($urandom_range(0, 1));
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
